// File: rtl/ov7670_captura_janela.sv
// OV7670 capture engine: synchronises the camera bus, pairs bytes into RGB565, crops/decimates a
// window and streams linear-addressed pixels. Define OV7670_SOMA_COR_EN to add per-frame colour sums.
module ov7670_captura_janela #(
    parameter int COLUMNS   = 640,
    parameter int LINES     = 480,
    parameter int X0        = 0,
    parameter int Y0        = 0,
    parameter int WIN_W     = 320,
    parameter int WIN_H     = 140,
    parameter int DEC       = 1,
    parameter int BYTE_SWAP = 0,
    parameter int S_COLUMN  = 10,
    parameter int S_LINE    = 9,
    parameter int S_ADDR    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              continuo,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic              PCLK,
    input  logic [7:0]        D,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [15:0]       px_data,
    output logic [S_ADDR-1:0] px_addr,
    output logic              frame_done,
    output logic              busy,
    output logic              overflow,
    output logic [3:0]        db_estado
`ifdef OV7670_SOMA_COR_EN
    ,
    output logic [S_ADDR+4:0] soma_r,
    output logic [S_ADDR+5:0] soma_g,
    output logic [S_ADDR+4:0] soma_b
`endif
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_FRAME = 2'd1;
    localparam logic [1:0] CAPTURE    = 2'd2;
    localparam logic [1:0] DONE       = 2'd3;

    localparam logic [S_COLUMN:0] X_LO    = (S_COLUMN+1)'(X0);
    localparam logic [S_COLUMN:0] X_SPAN  = (S_COLUMN+1)'(WIN_W);
    localparam logic [S_COLUMN:0] COL_MAX = (S_COLUMN+1)'(COLUMNS-1);
    localparam logic [S_LINE:0]   Y_LO    = (S_LINE+1)'(Y0);
    localparam logic [S_LINE:0]   Y_SPAN  = (S_LINE+1)'(WIN_H);
    localparam logic [S_LINE:0]   LIN_MAX = (S_LINE+1)'(LINES-1);
    localparam logic [2:0]        DEC_LAST = 3'(DEC-1);

    logic [1:0]          state;
    logic                vsync_p0, vsync_p1, vsync_p2;
    logic                href_p0, href_p1, href_p2;
    logic                pclk_p0, pclk_p1, pclk_p2;
    logic [7:0]          d_p0, d_p1;
    logic                ini_q;
    logic                phase;
    logic [7:0]          byte0;
    logic [S_COLUMN-1:0] col;
    logic                col_full;
    logic [S_LINE-1:0]   line;
    logic                line_full;
    logic [2:0]          col_dec, line_dec;
    logic [S_ADDR-1:0]   addr_cnt;

    logic                pclk_rise, href_fall, vsync_fall, vsync_rise, ini_rise;
    logic                byte_en, pix_done, in_x, in_y, keep, arm;
    logic [S_COLUMN:0]   off_x;
    logic [S_LINE:0]     off_y;
    logic [15:0]         pix_word;

    always_comb begin
        pclk_rise  = pclk_p1 & ~pclk_p2;
        href_fall  = ~href_p1 & href_p2;
        vsync_fall = ~vsync_p1 & vsync_p2;
        vsync_rise = vsync_p1 & ~vsync_p2;
        ini_rise   = iniciar & ~ini_q;
        byte_en    = (state == CAPTURE) && pclk_rise && href_p1;
        pix_done   = byte_en && phase;
        pix_word   = (BYTE_SWAP != 0) ? {d_p1, byte0} : {byte0, d_p1};
        // Offsets wrap to large values when below the window origin, so one compare covers both bounds.
        off_x      = {1'b0, col} - X_LO;
        off_y      = {1'b0, line} - Y_LO;
        in_x       = (off_x < X_SPAN) && !col_full;
        in_y       = (off_y < Y_SPAN) && !line_full;
        keep       = pix_done && in_x && in_y && (col_dec == 3'd0) && (line_dec == 3'd0);
        arm        = ((state == IDLE) && ini_rise) || ((state == DONE) && continuo);
        frame_done = (state == DONE);
        busy       = (state == WAIT_FRAME) || (state == CAPTURE);
        db_estado  = {2'b00, state};
    end

    // Data-path samples carry no reset; they are qualified by synchronised control before use.
    always_ff @(posedge clock) begin
        d_p0 <= D;
        d_p1 <= d_p0;
        if (byte_en && !phase)
            byte0 <= d_p1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            vsync_p0  <= 1'b0; vsync_p1 <= 1'b0; vsync_p2 <= 1'b0;
            href_p0   <= 1'b0; href_p1  <= 1'b0; href_p2  <= 1'b0;
            pclk_p0   <= 1'b0; pclk_p1  <= 1'b0; pclk_p2  <= 1'b0;
            ini_q     <= 1'b0;
            phase     <= 1'b0;
            col       <= '0;
            col_full  <= 1'b0;
            line      <= '0;
            line_full <= 1'b0;
            col_dec   <= 3'd0;
            line_dec  <= 3'd0;
            addr_cnt  <= '0;
            px_valid  <= 1'b0;
            px_data   <= 16'h0000;
            px_addr   <= '0;
            overflow  <= 1'b0;
        end else begin
            vsync_p0 <= VSYNC; vsync_p1 <= vsync_p0; vsync_p2 <= vsync_p1;
            href_p0  <= HREF;  href_p1  <= href_p0;  href_p2  <= href_p1;
            pclk_p0  <= PCLK;  pclk_p1  <= pclk_p0;  pclk_p2  <= pclk_p1;
            ini_q    <= iniciar;

            case (state)
                IDLE:       if (ini_rise)   state <= WAIT_FRAME;
                WAIT_FRAME: if (vsync_fall) state <= CAPTURE;
                CAPTURE:    if (vsync_rise) state <= DONE;
                default:    state <= continuo ? WAIT_FRAME : IDLE;
            endcase

            if ((state == WAIT_FRAME) && vsync_fall) begin
                phase     <= 1'b0;
                col       <= '0;
                col_full  <= 1'b0;
                line      <= '0;
                line_full <= 1'b0;
                col_dec   <= 3'd0;
                line_dec  <= 3'd0;
            end else if (state == CAPTURE) begin
                if (href_fall) begin
                    phase    <= 1'b0;
                    col      <= '0;
                    col_full <= 1'b0;
                    col_dec  <= 3'd0;
                    if ({1'b0, line} == LIN_MAX) line_full <= 1'b1;
                    else                          line      <= line + 1'b1;
                    if (in_y) line_dec <= (line_dec == DEC_LAST) ? 3'd0 : line_dec + 3'd1;
                end else if (byte_en) begin
                    phase <= ~phase;
                    if (phase) begin
                        if ({1'b0, col} == COL_MAX) col_full <= 1'b1;
                        else                         col      <= col + 1'b1;
                        if (in_x) col_dec <= (col_dec == DEC_LAST) ? 3'd0 : col_dec + 3'd1;
                    end
                end
            end

            if (arm) begin
                addr_cnt <= '0;
                if (state == IDLE) overflow <= 1'b0;
            end

            // A kept pixel always consumes an address, even when the output slot is still occupied.
            if (keep) begin
                addr_cnt <= addr_cnt + 1'b1;
                if (!px_valid || px_ready) begin
                    px_valid <= 1'b1;
                    px_data  <= pix_word;
                    px_addr  <= addr_cnt;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (px_valid && px_ready) begin
                px_valid <= 1'b0;
            end
        end
    end

`ifdef OV7670_SOMA_COR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            soma_r <= '0;
            soma_g <= '0;
            soma_b <= '0;
        end else if (arm) begin
            soma_r <= '0;
            soma_g <= '0;
            soma_b <= '0;
        end else if (keep) begin
            soma_r <= soma_r + {{S_ADDR{1'b0}}, pix_word[15:11]};
            soma_g <= soma_g + {{S_ADDR{1'b0}}, pix_word[10:5]};
            soma_b <= soma_b + {{S_ADDR{1'b0}}, pix_word[4:0]};
        end
    end
`endif

endmodule

// File: tb/tb_ov7670_captura_janela.sv
// Scoreboard bench: three DUT builds (plain, byte-swapped, decimated) share one camera stream;
// expected pixels are queued as bytes are driven and popped on each accepted handshake.
module tb_ov7670_captura_janela;

    localparam int NCOL = 8, NLIN = 4, WX0 = 2, WY0 = 1, WW = 4, WH = 2;

    logic             clock = 1'b0;
    logic             reset, iniciar, continuo, VSYNC, HREF, PCLK, px_ready;
    logic [7:0]       D;
    logic [2:0]       vld, fd, bsy, ovf;
    logic [2:0][15:0] dat, adr;
    logic [2:0][3:0]  est;
`ifdef OV7670_SOMA_COR_EN
    logic [2:0][20:0] sr, sb;
    logic [2:0][21:0] sg;
`endif

    logic [31:0] q0[$], q1[$], q2[$];
    int          n_cmp = 0, n_err = 0;
    int          fd_cnt[3] = '{0, 0, 0};

    always #5 clock = ~clock;

    ov7670_captura_janela #(.COLUMNS(NCOL), .LINES(NLIN), .X0(WX0), .Y0(WY0), .WIN_W(WW), .WIN_H(WH),
                            .DEC(1), .BYTE_SWAP(0)) u_plain (
        .clock(clock), .reset(reset), .iniciar(iniciar), .continuo(continuo), .VSYNC(VSYNC),
        .HREF(HREF), .PCLK(PCLK), .D(D), .px_valid(vld[0]), .px_ready(px_ready), .px_data(dat[0]),
        .px_addr(adr[0]), .frame_done(fd[0]), .busy(bsy[0]), .overflow(ovf[0]), .db_estado(est[0])
`ifdef OV7670_SOMA_COR_EN
        , .soma_r(sr[0]), .soma_g(sg[0]), .soma_b(sb[0])
`endif
    );

    ov7670_captura_janela #(.COLUMNS(NCOL), .LINES(NLIN), .X0(WX0), .Y0(WY0), .WIN_W(WW), .WIN_H(WH),
                            .DEC(1), .BYTE_SWAP(1)) u_swap (
        .clock(clock), .reset(reset), .iniciar(iniciar), .continuo(continuo), .VSYNC(VSYNC),
        .HREF(HREF), .PCLK(PCLK), .D(D), .px_valid(vld[1]), .px_ready(px_ready), .px_data(dat[1]),
        .px_addr(adr[1]), .frame_done(fd[1]), .busy(bsy[1]), .overflow(ovf[1]), .db_estado(est[1])
`ifdef OV7670_SOMA_COR_EN
        , .soma_r(sr[1]), .soma_g(sg[1]), .soma_b(sb[1])
`endif
    );

    ov7670_captura_janela #(.COLUMNS(NCOL), .LINES(NLIN), .X0(WX0), .Y0(WY0), .WIN_W(WW), .WIN_H(WH),
                            .DEC(2), .BYTE_SWAP(0)) u_dec (
        .clock(clock), .reset(reset), .iniciar(iniciar), .continuo(continuo), .VSYNC(VSYNC),
        .HREF(HREF), .PCLK(PCLK), .D(D), .px_valid(vld[2]), .px_ready(px_ready), .px_data(dat[2]),
        .px_addr(adr[2]), .frame_done(fd[2]), .busy(bsy[2]), .overflow(ovf[2]), .db_estado(est[2])
`ifdef OV7670_SOMA_COR_EN
        , .soma_r(sr[2]), .soma_g(sg[2]), .soma_b(sb[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_exp(input int i, output bit ok, output logic [31:0] v);
        ok = 1'b0;
        v  = '0;
        case (i)
            0: if (q0.size() > 0) begin ok = 1'b1; v = q0.pop_front(); end
            1: if (q1.size() > 0) begin ok = 1'b1; v = q1.pop_front(); end
            default: if (q2.size() > 0) begin ok = 1'b1; v = q2.pop_front(); end
        endcase
    endtask

    // Model of the window: plain and swapped keep every window pixel, decimated keeps even offsets.
    task automatic expect_px(input int c, input int l, input logic [7:0] b0, input logic [7:0] b1);
        int ox, oy;
        ox = c - WX0;
        oy = l - WY0;
        if (ox >= 0 && ox < WW && oy >= 0 && oy < WH) begin
            q0.push_back({16'(oy * WW + ox), b0, b1});
            q1.push_back({16'(oy * WW + ox), b1, b0});
            if ((ox % 2) == 0 && (oy % 2) == 0)
                q2.push_back({16'((oy / 2) * (WW / 2) + ox / 2), b0, b1});
        end
    endtask

    always @(negedge clock) begin
        bit          ok;
        logic [31:0] e;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                if (fd[i]) fd_cnt[i]++;
                if (vld[i] && px_ready) begin
                    pop_exp(i, ok, e);
                    if (!ok) check($sformatf("px%0d_unexpected", i), 32'd1, 32'd0);
                    else begin
                        check($sformatf("px%0d_data", i), 32'(dat[i]), 32'(e[15:0]));
                        check($sformatf("px%0d_addr", i), 32'(adr[i]), 32'(e[31:16]));
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        D = b;
        #40 PCLK = 1'b1;
        #40 PCLK = 1'b0;
    endtask

    // mode 0: pixel(c,l) bytes {l,c}; mode 1: AB then CD; mode 2: all FF.
    task automatic send_frame(input int mode, input bit push);
        logic [7:0] b0, b1;
        VSYNC = 1'b1; #200;
        VSYNC = 1'b0; #200;
        for (int l = 0; l < NLIN; l++) begin
            HREF = 1'b1; #40;
            for (int c = 0; c < NCOL; c++) begin
                case (mode)
                    0: begin b0 = 8'(l); b1 = 8'(c); end
                    1: begin b0 = 8'hAB; b1 = 8'hCD; end
                    default: begin b0 = 8'hFF; b1 = 8'hFF; end
                endcase
                if (push) expect_px(c, l, b0, b1);
                send_byte(b0);
                send_byte(b1);
            end
            #40 HREF = 1'b0; #200;
        end
        VSYNC = 1'b1; #300;
    endtask

    task automatic start();
        iniciar = 1'b1; #40;
        iniciar = 1'b0; #40;
    endtask

    task automatic check_cleared(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_valid%0d", tag, i), 32'(vld[i]), 32'd0);
            check($sformatf("%s_data%0d", tag, i), 32'(dat[i]), 32'd0);
            check($sformatf("%s_addr%0d", tag, i), 32'(adr[i]), 32'd0);
            check($sformatf("%s_done%0d", tag, i), 32'(fd[i]), 32'd0);
            check($sformatf("%s_busy%0d", tag, i), 32'(bsy[i]), 32'd0);
            check($sformatf("%s_ovf%0d", tag, i), 32'(ovf[i]), 32'd0);
            check($sformatf("%s_state%0d", tag, i), 32'(est[i]), 32'd0);
`ifdef OV7670_SOMA_COR_EN
            check($sformatf("%s_somar%0d", tag, i), 32'(sr[i]), 32'd0);
`endif
        end
    endtask

    task automatic check_done_count(input string tag, input int base[3], input int n);
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_frame_done%0d", tag, i), 32'(fd_cnt[i] - base[i]), 32'(n));
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_q0_left"}, 32'(q0.size()), 32'd0);
        check({tag, "_q1_left"}, 32'(q1.size()), 32'd0);
        check({tag, "_q2_left"}, 32'(q2.size()), 32'd0);
    endtask

    initial begin
        int base[3];
        reset = 1'b0; iniciar = 1'b0; continuo = 1'b0; VSYNC = 1'b1; HREF = 1'b0;
        PCLK = 1'b0; D = 8'h00; px_ready = 1'b1;
        #27;
        check_cleared("rst");
        reset = 1'b1; #40;

        // Plain {l,c} frame, then constant AB/CD frame.
        for (int m = 0; m < 2; m++) begin
            base = fd_cnt;
            start();
            check($sformatf("m%0d_busy", m), 32'(bsy[0]), 32'd1);
            check($sformatf("m%0d_state", m), 32'(est[0]), 32'd1);
            send_frame(m, 1'b1);
            check_done_count($sformatf("m%0d", m), base, 1);
            check($sformatf("m%0d_idle", m), 32'(est[0]), 32'd0);
            check_drained($sformatf("m%0d", m));
        end

        base = fd_cnt;
        start();
        send_frame(2, 1'b1);
        check_done_count("ff", base, 1);
        check_drained("ff");
`ifdef OV7670_SOMA_COR_EN
        check("ff_somar0", 32'(sr[0]), 32'd248);
        check("ff_somag0", 32'(sg[0]), 32'd504);
        check("ff_somab0", 32'(sb[0]), 32'd248);
        check("ff_somar2", 32'(sr[2]), 32'd62);
`endif

        // No acceptance for a whole frame: first pixel is held, the rest are dropped.
        px_ready = 1'b0;
        base = fd_cnt;
        start();
        send_frame(0, 1'b0);
        check_done_count("bp", base, 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_valid%0d", i), 32'(vld[i]), 32'd1);
            check($sformatf("bp_addr%0d", i), 32'(adr[i]), 32'd0);
            check($sformatf("bp_ovf%0d", i), 32'(ovf[i]), 32'd1);
        end
        check("bp_data0", 32'(dat[0]), 32'h0102);
        check("bp_data1", 32'(dat[1]), 32'h0201);
        q0.push_back({16'd0, 16'h0102});
        q1.push_back({16'd0, 16'h0201});
        q2.push_back({16'd0, 16'h0102});
        px_ready = 1'b1; #40;
        check("bp_released", 32'(vld[0]), 32'd0);
        check("bp_ovf_sticky", 32'(ovf[0]), 32'd1);
        check_drained("bp");

        // Continuous mode across two frames.
        continuo = 1'b1;
        base = fd_cnt;
        start();
        check("cont_ovf_cleared", 32'(ovf[0]), 32'd0);
        send_frame(0, 1'b1);
        check("cont_busy_gap", 32'(bsy[0]), 32'd1);
        check("cont_state_gap", 32'(est[0]), 32'd1);
        send_frame(0, 1'b1);
        check_done_count("cont", base, 2);
        check("cont_busy_end", 32'(bsy[0]), 32'd1);
        check_drained("cont");

        // Asynchronous reset in the middle of a captured line, with a pixel held on the output.
        continuo = 1'b0;
        px_ready = 1'b0;
        VSYNC = 1'b0; #200;
        HREF = 1'b1; #40;
        send_byte(8'h00); send_byte(8'h00);
        #40 HREF = 1'b0; #200;
        HREF = 1'b1; #40;
        for (int c = 0; c < 3; c++) begin
            send_byte(8'h01);
            send_byte(8'(c));
        end
        check("mid_state", 32'(est[0]), 32'd2);
        check("mid_valid", 32'(vld[0]), 32'd1);
        reset = 1'b0; #1;
        check_cleared("arst");
        #9 reset = 1'b1;
        HREF = 1'b0; #40;
        VSYNC = 1'b1; #200;
        VSYNC = 1'b0; #200;
        check("arst_no_rearm", 32'(est[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
